meas_seq_ctrl: RTL and testbench
================================

MEAS_SEQ_CTRL -- requirements
Module: meas_seq_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, measurement gate length in sysclk cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, wait after generator reconfiguration before gating.
REQ-003 SHALL have parameter CNT_W, default 24, edge-counter/result width.
REQ-004 sysclk  in  1  system clock, 100 MHz; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin measurement sequence; sampled only in IDLE.
REQ-007 abort  in  1  terminate sequence, return to IDLE.
REQ-008 auto_mode  in  1  1 = sweep testmode 00..11; 0 = single measurement at man_mode.
REQ-009 man_mode  in  2  testmode for single measurement.
REQ-010 sigin  in  1  test signal from generator, synchronous to sysclk.
REQ-011 testmode  out  2  frequency select driven to generator.
REQ-012 gen_rst_n  out  1  active-low generator reset.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 result  out  CNT_W  rising-edge count of last completed gate.
REQ-015 result_mode  out  2  testmode of that result.
REQ-016 result_valid  out  1  one-cycle pulse per completed measurement.
REQ-017 overflow  out  1  result saturated; updated with result.
REQ-018 done  out  1  one-cycle pulse at end of full sequence.

Function
REQ-019 FSM states SHALL be IDLE, CFG, SETTLE, GATE, LATCH, FIN; one state register, transitions on sysclk rising edge.
REQ-020 IDLE: start=1 and abort=0 -> CFG; testmode loads 00 if auto_mode=1, else man_mode; auto_mode latched for the sequence.
REQ-021 CFG: exactly 1 cycle, gen_rst_n=0; -> SETTLE. gen_rst_n=1 in every other state.
REQ-022 SETTLE: exactly SETTLE_CYCLES cycles, edges not counted; -> GATE.
REQ-023 GATE: exactly GATE_CYCLES cycles; edge counter cleared on entry; increments on each cycle with sigin=1 and previous-cycle sigin=0; -> LATCH.
REQ-024 Edge detector: sigin delay register updates every cycle in all states.
REQ-025 Counter SHALL saturate at 2^CNT_W-1; further edges set internal ovf flag, never wrap.
REQ-026 LATCH: exactly 1 cycle; result, result_mode, overflow are stable and result_valid=1 during this cycle; values hold until next LATCH or rst.
REQ-027 From LATCH: latched auto=1 and testmode<11 -> CFG with testmode+1; else -> FIN.
REQ-028 FIN: 1 cycle, done=1; -> IDLE. testmode keeps last value in IDLE.
REQ-029 Latency: start sampled in cycle T -> result_valid in cycle T+2+SETTLE_CYCLES+GATE_CYCLES; auto sweep: 4 result_valid pulses spaced 2+SETTLE_CYCLES+GATE_CYCLES cycles apart, done 1 cycle after the 4th.
REQ-030 start while busy SHALL be ignored; auto_mode/man_mode changes while busy have no effect.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle; no result_valid, no done; result/overflow keep prior values; gen_rst_n=1.
REQ-032 abort and start both high in IDLE: abort wins, stay IDLE.
REQ-033 abort during LATCH: result_valid still pulses that cycle, then IDLE, no done.
REQ-034 Counter widths for GATE/SETTLE timers SHALL be sized to parameters; SETTLE_CYCLES and GATE_CYCLES >= 1.

Reset
REQ-035 rst=1 SHALL force next cycle: state IDLE, testmode=00, gen_rst_n=1, busy=0, result=0, result_mode=00, result_valid=0, overflow=0, done=0, counters and edge register 0.
REQ-036 rst mid-sequence SHALL take precedence over start/abort and discard the measurement in progress.

Verification (GATE_CYCLES=64, SETTLE_CYCLES=4, CNT_W=24, sigin from team 2-bit divide generator, rst active-low = gen_rst_n)
REQ-037 auto_mode=1, start pulse -> result_valid 4x, 70 cycles apart; results 2,4,0,8 with result_mode 00,01,10,11; overflow=0; done 1 cycle after 4th.
REQ-038 auto_mode=0, man_mode=11, start -> one result_valid 70 cycles after start, result=8, then done; busy low after.
REQ-039 CNT_W=3, man_mode=11 -> result=7, overflow=1.
REQ-040 abort asserted in GATE cycle 30 -> IDLE next cycle, no result_valid/done, result retains previous value; start pulses during the sequence ignored.
REQ-041 rst asserted during SETTLE of 2nd auto step -> all outputs at reset values next cycle; fresh start yields 2,4,0,8.

Source files
------------

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: configures the signal generator, waits for it to settle, counts
// rising edges of sigin over a fixed gate and publishes the count, optionally sweeping all modes.
module meas_seq_ctrl #(
    parameter int unsigned GATE_CYCLES   = 100000000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             auto_mode,
    input  logic [1:0]       man_mode,
    input  logic             sigin,
    output logic [1:0]       testmode,
    output logic             gen_rst_n,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic [1:0]       result_mode,
    output logic             result_valid,
    output logic             overflow,
    output logic             done
);

    localparam int unsigned MAX_CYCLES =
        (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    // One timer serves both SETTLE and GATE; it only ever counts 0 .. N-1.
    localparam int unsigned TMR_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCfg    = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StGate   = 3'd3;
    localparam logic [2:0] StLatch  = 3'd4;
    localparam logic [2:0] StFin    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [1:0]       testmode_q, testmode_d;
    logic             auto_q, auto_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic [1:0]       result_mode_q, result_mode_d;
    logic             overflow_q, overflow_d;
    logic             sigin_q;
    logic             sig_rise;

    assign sig_rise = sigin & ~sigin_q;

    always_comb begin
        state_d       = state_q;
        testmode_d    = testmode_q;
        auto_d        = auto_q;
        tmr_d         = tmr_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        result_d      = result_q;
        result_mode_d = result_mode_q;
        overflow_d    = overflow_q;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = StCfg;
                    auto_d     = auto_mode;
                    testmode_d = auto_mode ? 2'b00 : man_mode;
                end
            end
            StCfg: begin
                state_d = StSettle;
                tmr_d   = '0;
            end
            StSettle: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = StGate;
                    tmr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StGate: begin
                if (sig_rise) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Publish on the last gate cycle so the values are already stable in LATCH.
                if (tmr_q == GATE_LAST) begin
                    state_d       = StLatch;
                    result_d      = cnt_d;
                    overflow_d    = ovf_d;
                    result_mode_d = testmode_q;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StLatch: begin
                if (auto_q && (testmode_q != 2'b11)) begin
                    state_d    = StCfg;
                    testmode_d = testmode_q + 2'd1;
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards any half-finished gate and leaves published results untouched.
        if (abort && (state_q != StIdle)) begin
            state_d       = StIdle;
            testmode_d    = testmode_q;
            result_d      = result_q;
            result_mode_d = result_mode_q;
            overflow_d    = overflow_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q       <= StIdle;
            testmode_q    <= 2'b00;
            auto_q        <= 1'b0;
            tmr_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            result_q      <= '0;
            result_mode_q <= 2'b00;
            overflow_q    <= 1'b0;
            sigin_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            testmode_q    <= testmode_d;
            auto_q        <= auto_d;
            tmr_q         <= tmr_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            result_q      <= result_d;
            result_mode_q <= result_mode_d;
            overflow_q    <= overflow_d;
            sigin_q       <= sigin;
        end
    end

    assign testmode     = testmode_q;
    assign gen_rst_n    = (state_q != StCfg);
    assign busy         = (state_q != StIdle);
    assign result       = result_q;
    assign result_mode  = result_mode_q;
    assign result_valid = (state_q == StLatch);
    assign overflow     = overflow_q;
    assign done         = (state_q == StFin);

    a_valid_done_excl: assert property (@(posedge sysclk) disable iff (rst)
        !(result_valid && done));
    a_abort_to_idle: assert property (@(posedge sysclk) disable iff (rst)
        (abort && busy) |=> !busy);
    a_start_to_busy: assert property (@(posedge sysclk) disable iff (rst)
        (start && !abort && !busy) |=> busy);

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Bench for meas_seq_ctrl: two instances (wide and 3-bit counter) with a divide-by generator
// model each, checked against a queue of expected results and done pulses.
module tb_meas_seq_ctrl;

    localparam int GATE   = 64;
    localparam int SETTLE = 4;
    localparam int STEP   = 2 + SETTLE + GATE;

    typedef struct {
        logic [1:0]  mode;
        int unsigned edges;
        int          cyc;
    } exp_t;

    logic sysclk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic auto_mode = 1'b0;
    logic [1:0] man_mode = 2'b00;

    logic [1:0]  testmode_a, result_mode_a;
    logic        gen_rst_n_a, busy_a, result_valid_a, overflow_a, done_a, sigin_a;
    logic [23:0] result_a;
    logic [1:0]  testmode_b, result_mode_b;
    logic        gen_rst_n_b, busy_b, result_valid_b, overflow_b, done_b, sigin_b;
    logic [2:0]  result_b;

    logic [7:0] gcnt_a = 8'd0;
    logic [7:0] gcnt_b = 8'd0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   dq_a[$];
    int   dq_b[$];
    exp_t e_a, e_b;

    // Edges expected in one gate for testmode 00..11.
    int unsigned edge_tbl [4] = '{2, 4, 0, 8};

    meas_seq_ctrl #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(24)) dut_a (
        .sysclk(sysclk), .rst(rst), .start(start), .abort(abort), .auto_mode(auto_mode),
        .man_mode(man_mode), .sigin(sigin_a), .testmode(testmode_a), .gen_rst_n(gen_rst_n_a),
        .busy(busy_a), .result(result_a), .result_mode(result_mode_a),
        .result_valid(result_valid_a), .overflow(overflow_a), .done(done_a)
    );

    meas_seq_ctrl #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut_b (
        .sysclk(sysclk), .rst(rst), .start(start), .abort(abort), .auto_mode(auto_mode),
        .man_mode(man_mode), .sigin(sigin_b), .testmode(testmode_b), .gen_rst_n(gen_rst_n_b),
        .busy(busy_b), .result(result_b), .result_mode(result_mode_b),
        .result_valid(result_valid_b), .overflow(overflow_b), .done(done_b)
    );

    function automatic logic gen_out(input logic [1:0] mode, input logic [7:0] cnt);
        case (mode)
            2'b00:   return cnt[4];
            2'b01:   return cnt[3];
            2'b10:   return 1'b0;
            default: return cnt[2];
        endcase
    endfunction

    always @(posedge sysclk) gcnt_a <= gen_rst_n_a ? gcnt_a + 8'd1 : 8'd0;
    always @(posedge sysclk) gcnt_b <= gen_rst_n_b ? gcnt_b + 8'd1 : 8'd0;
    assign sigin_a = gen_out(testmode_a, gcnt_a);
    assign sigin_b = gen_out(testmode_b, gcnt_b);

    initial forever #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge sysclk) begin
        if (result_valid_a) begin
            if (q_a.size() == 0) begin
                check("a_valid_unexpected", 1, 0);
            end else begin
                e_a = q_a.pop_front();
                check("a_result", 32'(result_a), e_a.edges);
                check("a_result_mode", 32'(result_mode_a), 32'(e_a.mode));
                check("a_overflow", 32'(overflow_a), 0);
                check("a_valid_cycle", cyc, e_a.cyc);
            end
        end
        if (done_a) begin
            if (dq_a.size() == 0) check("a_done_unexpected", 1, 0);
            else check("a_done_cycle", cyc, dq_a.pop_front());
        end
    end

    always @(negedge sysclk) begin
        if (result_valid_b) begin
            if (q_b.size() == 0) begin
                check("b_valid_unexpected", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                check("b_result", 32'(result_b), (e_b.edges > 7) ? 7 : e_b.edges);
                check("b_result_mode", 32'(result_mode_b), 32'(e_b.mode));
                check("b_overflow", 32'(overflow_b), (e_b.edges > 7) ? 1 : 0);
                check("b_valid_cycle", cyc, e_b.cyc);
            end
        end
        if (done_b) begin
            if (dq_b.size() == 0) check("b_done_unexpected", 1, 0);
            else check("b_done_cycle", cyc, dq_b.pop_front());
        end
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Start sampled in cycle c: results every STEP cycles, done one cycle after the last.
    task automatic expect_seq(input logic auto_m, input logic [1:0] mode, input int c);
        exp_t e;
        int n = auto_m ? 4 : 1;
        for (int k = 0; k < n; k++) begin
            e.mode  = auto_m ? 2'(k) : mode;
            e.edges = edge_tbl[e.mode];
            e.cyc   = c + STEP * (k + 1);
            q_a.push_back(e);
            q_b.push_back(e);
        end
        dq_a.push_back(c + STEP * n + 1);
        dq_b.push_back(c + STEP * n + 1);
    endtask

    task automatic pulse_start(output int c);
        c = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_a.size() + q_b.size() + dq_a.size() + dq_b.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", q_a.size() + q_b.size() + dq_a.size() + dq_b.size(), 0);
        q_a.delete(); q_b.delete(); dq_a.delete(); dq_b.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_testmode"}, 32'(testmode_a), 0);
        check({tag, "_gen_rst_n"}, 32'(gen_rst_n_a), 1);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_result"}, 32'(result_a), 0);
        check({tag, "_result_mode"}, 32'(result_mode_a), 0);
        check({tag, "_valid"}, 32'(result_valid_a), 0);
        check({tag, "_overflow"}, 32'(overflow_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_b_result"}, 32'(result_b), 0);
        check({tag, "_b_overflow"}, 32'(overflow_b), 0);
    endtask

    initial begin
        int c;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Auto sweep; mode inputs change while busy and must be ignored.
        auto_mode = 1'b1;
        man_mode  = 2'b11;
        tick();
        pulse_start(c);
        expect_seq(1'b1, 2'b00, c);
        auto_mode = 1'b0;
        man_mode  = 2'b10;
        drain(5 * STEP);
        check("auto_idle_busy", 32'(busy_a), 0);

        // Single measurement at mode 11 (saturates the 3-bit instance).
        man_mode = 2'b11;
        tick();
        pulse_start(c);
        expect_seq(1'b0, 2'b11, c);
        drain(2 * STEP);
        check("man_idle_busy", 32'(busy_a), 0);
        check("man_testmode_kept", 32'(testmode_a), 3);

        // Abort wins over start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick();
        check("abort_start_busy", 32'(busy_a), 0);
        abort = 1'b0;
        start = 1'b0;
        tick();

        // Abort in gate cycle 30; a start pulse mid-sequence is ignored.
        man_mode = 2'b01;
        pulse_start(c);
        wait_until(c + 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(c + 2 + SETTLE + 29);
        check("pre_abort_busy", 32'(busy_a), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy_a), 0);
        check("abort_gen_rst_n", 32'(gen_rst_n_a), 1);
        check("abort_result_kept", 32'(result_a), 8);
        check("abort_mode_kept", 32'(result_mode_a), 3);
        check("abort_ovf_kept", 32'(overflow_a), 0);
        check("abort_b_result_kept", 32'(result_b), 7);
        check("abort_b_ovf_kept", 32'(overflow_b), 1);
        repeat (2 * STEP) tick();
        check("abort_still_idle", 32'(busy_a), 0);

        // Reset during SETTLE of the second auto step, then a fresh sweep.
        auto_mode = 1'b1;
        pulse_start(c);
        expect_seq(1'b1, 2'b00, c);
        wait_until(c + STEP + 3);
        check("rst_pending", q_a.size(), 3);
        check("rst_in_settle_busy", 32'(busy_a), 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        q_a.delete(); q_b.delete(); dq_a.delete(); dq_b.delete();
        tick();
        pulse_start(c);
        expect_seq(1'b1, 2'b00, c);
        drain(5 * STEP);
        check("final_busy", 32'(busy_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
